// File: rtl/mux_sel_ctrl.sv
// Pushbutton-to-mux-select controller: 2-flop synchroniser, debounce FSM, toggle-on-press select register.
// Optional auto-toggle timer is enabled by defining MUX_SEL_AUTO_EN (adds the auto_en port).
module mux_sel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_raw,
    input  logic sel_load,
    input  logic sel_val,
`ifdef MUX_SEL_AUTO_EN
    input  logic auto_en,
`endif
    output logic btn_clean,
    output logic sel,
    output logic sel_changed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Both periods must allow at least one counting cycle.
    if (DEBOUNCE_CYCLES < 2 || AUTO_PERIOD < 2) begin : g_param_check
        $error("mux_sel_ctrl: DEBOUNCE_CYCLES and AUTO_PERIOD must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          s1;
    logic          s2;
    logic          press_accept;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE_LO;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: a level must persist DEBOUNCE_CYCLES synced cycles to be accepted
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE_LO: begin
                if (s2) begin
                    state_next = WAIT_HI;
                    cnt_next   = CW'(1);
                end
            end
            WAIT_HI: begin
                if (!s2) begin
                    state_next = IDLE_LO;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE_HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            IDLE_HI: begin
                if (!s2) begin
                    state_next = WAIT_LO;
                    cnt_next   = CW'(1);
                end
            end
            WAIT_LO: begin
                if (s2) begin
                    state_next = IDLE_HI;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE_LO;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE_LO;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic: derived only from registered state, so no input reaches an output combinationally
    always_comb begin
        btn_clean    = 1'b0;
        press_accept = 1'b0;
        if (state == IDLE_HI || state == WAIT_LO) begin
            btn_clean = 1'b1;
        end
        if (state == WAIT_HI && s2 && cnt == CNT_MAX) begin
            press_accept = 1'b1;
        end
    end

`ifdef MUX_SEL_AUTO_EN
    localparam int AW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_PERIOD - 1);

    logic [AW-1:0] auto_cnt;
    logic          auto_en_q;
    logic          auto_fire;

    // auto_en_q holds the count at zero on the first enabled edge, so the first toggle lands AUTO_PERIOD edges later
    assign auto_fire = auto_en && auto_en_q && (auto_cnt == AUTO_MAX);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            auto_cnt  <= '0;
            auto_en_q <= 1'b0;
        end else begin
            auto_en_q <= auto_en;
            if (!auto_en || !auto_en_q || sel_load || press_accept || auto_fire) begin
                auto_cnt <= '0;
            end else begin
                auto_cnt <= auto_cnt + AW'(1);
            end
        end
    end
`endif

    // Select register; priority is load, then press, then auto
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sel         <= 1'b0;
            sel_changed <= 1'b0;
        end else begin
            sel_changed <= 1'b0;
            if (sel_load) begin
                sel         <= sel_val;
                sel_changed <= (sel_val != sel);
            end else if (press_accept) begin
                sel         <= ~sel;
                sel_changed <= 1'b1;
`ifdef MUX_SEL_AUTO_EN
            end else if (auto_fire) begin
                sel         <= ~sel;
                sel_changed <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed bench for mux_sel_ctrl (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8).
// Outputs are sampled 1 time unit after each rising edge; auto-toggle cases compile only with MUX_SEL_AUTO_EN.
module tb_mux_sel_ctrl;

    logic clock;
    logic reset_n;
    logic btn_raw;
    logic sel_load;
    logic sel_val;
`ifdef MUX_SEL_AUTO_EN
    logic auto_en;
`endif
    logic btn_clean;
    logic sel;
    logic sel_changed;

    int   n_checks;
    int   n_pass;
    logic model_sel;

    mux_sel_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_PERIOD    (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .sel_load   (sel_load),
        .sel_val    (sel_val),
`ifdef MUX_SEL_AUTO_EN
        .auto_en    (auto_en),
`endif
        .btn_clean  (btn_clean),
        .sel        (sel),
        .sel_changed(sel_changed)
    );

    // Clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        reset_n  = 1'b0;
        btn_raw  = 1'b0;
        sel_load = 1'b0;
        sel_val  = 1'b0;
`ifdef MUX_SEL_AUTO_EN
        auto_en  = 1'b0;
`endif
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] obs;
        reset_n = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            obs = {btn_clean, sel, sel_changed};
            n_checks++;
            if (obs !== 3'b000) $display("FAIL reset_hold edge %0d: clean/sel/chg=%b expected 000", i, obs);
            else n_pass++;
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            obs = {btn_clean, sel, sel_changed};
            n_checks++;
            if (obs !== 3'b000) $display("FAIL reset_idle edge %0d: clean/sel/chg=%b expected 000", i, obs);
            else n_pass++;
        end
        model_sel = 1'b0;
    endtask

    // Press held for `hold` edges; optionally a load strobe lands on the accept edge (edge 6).
    // Then release and check the release never toggles.
    task automatic run_press(input int hold, input bit load_at_accept, input logic lval, input string name);
        logic       prev;
        logic [2:0] exp;
        logic [2:0] obs;
        prev    = model_sel;
        btn_raw = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            sel_load = load_at_accept && (i == 6);
            sel_val  = lval;
            tick();
            exp = {(i >= 6), model_sel, 1'b0};
            if (i == 6) begin
                if (load_at_accept) begin
                    model_sel = lval;
                    exp = {1'b1, lval, lval != prev};
                end else begin
                    model_sel = ~prev;
                    exp = {1'b1, ~prev, 1'b1};
                end
            end
            obs = {btn_clean, sel, sel_changed};
            n_checks++;
            if (obs !== exp) $display("FAIL %s_hold edge %0d: clean/sel/chg=%b expected %b", name, i, obs, exp);
            else n_pass++;
        end
        sel_load = 1'b0;
        btn_raw  = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = {(i < 6), model_sel, 1'b0};
            obs = {btn_clean, sel, sel_changed};
            n_checks++;
            if (obs !== exp) $display("FAIL %s_release edge %0d: clean/sel/chg=%b expected %b", name, i, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_press_hold();
        run_press(20, 1'b0, 1'b0, "press");
        run_press(8, 1'b0, 1'b0, "press2");
    endtask

    task automatic test_bounce();
        logic [4:0] pattern;
        logic [2:0] obs;
        pattern = 5'b10110;
        for (int i = 0; i < 12; i++) begin
            btn_raw = (i < 5) ? pattern[4-i] : 1'b0;
            tick();
            obs = {btn_clean, sel, sel_changed};
            n_checks++;
            if (obs !== {1'b0, model_sel, 1'b0}) $display("FAIL bounce edge %0d: clean/sel/chg=%b expected %b", i, obs, {1'b0, model_sel, 1'b0});
            else n_pass++;
        end
    endtask

    task automatic test_load();
        logic [2:0] obs;
        logic [2:0] exp;
        logic       v;
        for (int k = 0; k < 4; k++) begin
            v = (k == 1) ? model_sel : ~model_sel;
            exp = {1'b0, v, v != model_sel};
            sel_load = 1'b1;
            sel_val  = v;
            tick();
            model_sel = v;
            obs = {btn_clean, sel, sel_changed};
            n_checks++;
            if (obs !== exp) $display("FAIL load_%0d: clean/sel/chg=%b expected %b", k, obs, exp);
            else n_pass++;
            sel_load = 1'b0;
            tick();
            obs = {btn_clean, sel, sel_changed};
            n_checks++;
            if (obs !== {1'b0, model_sel, 1'b0}) $display("FAIL load_after_%0d: clean/sel/chg=%b expected %b", k, obs, {1'b0, model_sel, 1'b0});
            else n_pass++;
        end
    endtask

    task automatic test_load_vs_press();
        sel_load = 1'b1;
        sel_val  = 1'b0;
        tick();
        sel_load  = 1'b0;
        model_sel = 1'b0;
        tick();
        n_checks++;
        if (sel !== 1'b0) $display("FAIL lvp_setup: sel=%b expected 0", sel);
        else n_pass++;
        run_press(10, 1'b1, 1'b0, "lvp_same");
        run_press(10, 1'b1, 1'b1, "lvp_set");
    endtask

    task automatic test_reset_mid_debounce();
        logic [2:0] obs;
        logic [2:0] exp;
        sel_load = 1'b1;
        sel_val  = 1'b1;
        tick();
        sel_load  = 1'b0;
        model_sel = 1'b1;
        btn_raw   = 1'b1;
        for (int i = 1; i <= 4; i++) tick();
        reset_n = 1'b0;
        tick();
        obs = {btn_clean, sel, sel_changed};
        n_checks++;
        if (obs !== 3'b000) $display("FAIL mid_reset: clean/sel/chg=%b expected 000", obs);
        else n_pass++;
        reset_n   = 1'b1;
        model_sel = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = (i < 6) ? 3'b000 : (i == 6) ? 3'b111 : 3'b110;
            obs = {btn_clean, sel, sel_changed};
            n_checks++;
            if (obs !== exp) $display("FAIL mid_reset_redebounce edge %0d: clean/sel/chg=%b expected %b", i, obs, exp);
            else n_pass++;
        end
        model_sel = 1'b1;
        btn_raw   = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
        n_checks++;
        if ({btn_clean, sel, sel_changed} !== 3'b010) $display("FAIL mid_reset_settle: clean/sel/chg=%b expected 010", {btn_clean, sel, sel_changed});
        else n_pass++;
    endtask

`ifdef MUX_SEL_AUTO_EN
    // press_edge = 0 means no press; otherwise btn_raw rises before edge press_edge-5 so the accept is at press_edge.
    task automatic run_auto(input int press_edge, input string name);
        logic [2:0] obs;
        logic [2:0] exp;
        bit         fire;
        int         next_auto;
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        model_sel = 1'b0;
        auto_en   = 1'b1;
        tick();
        next_auto = 8;
        for (int e = 1; e <= 26; e++) begin
            if (press_edge != 0 && e == press_edge - 5) btn_raw = 1'b1;
            tick();
            fire = 1'b0;
            if (press_edge != 0 && e == press_edge) begin
                fire = 1'b1;
                next_auto = e + 8;
            end else if (e == next_auto) begin
                fire = 1'b1;
                next_auto = e + 8;
            end
            if (fire) model_sel = ~model_sel;
            exp = {(press_edge != 0 && e >= press_edge), model_sel, fire};
            obs = {btn_clean, sel, sel_changed};
            n_checks++;
            if (obs !== exp) $display("FAIL %s edge %0d: clean/sel/chg=%b expected %b", name, e, obs, exp);
            else n_pass++;
        end
        auto_en = 1'b0;
        btn_raw = 1'b0;
        for (int i = 1; i <= 10; i++) tick();
        n_checks++;
        if ({btn_clean, sel, sel_changed} !== {1'b0, model_sel, 1'b0}) $display("FAIL %s_settle: clean/sel/chg=%b expected %b", name, {btn_clean, sel, sel_changed}, {1'b0, model_sel, 1'b0});
        else n_pass++;
    endtask

    task automatic test_auto();
        run_auto(0, "auto");
        run_auto(12, "auto_press");
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        model_sel = 1'b0;
        #2;
        test_reset();
        test_press_hold();
        test_bounce();
        test_load();
        test_load_vs_press();
        test_reset_mid_debounce();
`ifdef MUX_SEL_AUTO_EN
        test_auto();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
